// File: rtl/lzrw1_decompressor.sv
// lzrw1_decompressor: streaming LZRW1 item decoder with a HIST_DEPTH-byte history window.
// Optional offset bounds checking is enabled by defining LZRW1_DEC_BOUNDS_CHECK_EN.
`timescale 1ns/1ps
module lzrw1_decompressor #(
    parameter int unsigned HIST_DEPTH = 4096,
    parameter int unsigned OFFSET_W   = 12,
    parameter int unsigned LEN_W      = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_ctrl,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       err,
    output logic       busy
);

    localparam int unsigned OFF_HI_W = OFFSET_W - 8;
    localparam int unsigned REM_W    = LEN_W + 1;

    typedef enum logic [1:0] {
        S_ITEM  = 2'd0,
        S_OFFLO = 2'd1,
        S_COPY  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           out_data_q, out_data_d;
    logic [OFFSET_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OFFSET_W-1:0]  off_q, off_d;
    logic [OFF_HI_W-1:0]  off_hi_q, off_hi_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [REM_W-1:0]     remain_q, remain_d;
`ifdef LZRW1_DEC_BOUNDS_CHECK_EN
    logic [OFFSET_W-1:0]  fill_q, fill_d;
    logic                 err_q, err_d;
`endif

    logic [7:0]           hist_q [HIST_DEPTH];

    logic                 slot;
    logic                 lit_acc;
    logic                 hdr_acc;
    logic                 off_acc;
    logic                 emit;
    logic                 off_ok;
    logic                 wr_en;
    logic [OFFSET_W-1:0]  off_full;
    logic [OFFSET_W-1:0]  src_addr;
    logic [7:0]           hist_rd;
    logic [7:0]           wr_byte;

    // Output register may advance or drain this cycle.
    assign slot     = !out_valid_q || out_ready;
    assign off_full = {off_hi_q, in_data};
    assign src_addr = wr_ptr_q - off_q;
    assign hist_rd  = hist_q[src_addr];
    assign wr_en    = lit_acc || emit;
    assign wr_byte  = lit_acc ? in_data : hist_rd;

`ifdef LZRW1_DEC_BOUNDS_CHECK_EN
    // An offset must point into bytes already produced.
    assign off_ok = (off_full != '0) && (off_full <= fill_q);
    assign err    = err_q;
`else
    assign off_ok = 1'b1;
    assign err    = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_ITEM);

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ITEM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ITEM: begin
                if (in_valid && slot && in_ctrl) begin
                    state_d = S_OFFLO;
                end
            end
            S_OFFLO: begin
                if (in_valid) begin
                    state_d = off_ok ? S_COPY : S_ITEM;
                end
            end
            S_COPY: begin
                if (slot && (remain_q == REM_W'(1))) begin
                    state_d = S_ITEM;
                end
            end
            default: state_d = S_ITEM;
        endcase
    end

    // FSM outputs: handshake and datapath strobes.
    always_comb begin
        in_ready = 1'b0;
        lit_acc  = 1'b0;
        hdr_acc  = 1'b0;
        off_acc  = 1'b0;
        emit     = 1'b0;
        case (state_q)
            S_ITEM: begin
                in_ready = slot;
                if (in_valid && slot) begin
                    lit_acc = !in_ctrl;
                    hdr_acc = in_ctrl;
                end
            end
            S_OFFLO: begin
                in_ready = 1'b1;
                off_acc  = in_valid;
            end
            S_COPY: begin
                emit = slot;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath next-state: output register, pointers, item fields.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        wr_ptr_d    = wr_ptr_q;
        off_d       = off_q;
        off_hi_d    = off_hi_q;
        len_d       = len_q;
        remain_d    = remain_q;
`ifdef LZRW1_DEC_BOUNDS_CHECK_EN
        fill_d      = fill_q;
        err_d       = err_q;
`endif
        if (wr_en) begin
            out_valid_d = 1'b1;
            out_data_d  = wr_byte;
            wr_ptr_d    = wr_ptr_q + OFFSET_W'(1);
`ifdef LZRW1_DEC_BOUNDS_CHECK_EN
            if (fill_q != {OFFSET_W{1'b1}}) begin
                fill_d = fill_q + OFFSET_W'(1);
            end
`endif
        end else if (slot) begin
            out_valid_d = 1'b0;
        end
        if (hdr_acc) begin
            len_d    = in_data[OFF_HI_W +: LEN_W];
            off_hi_d = in_data[OFF_HI_W-1:0];
        end
        if (off_acc) begin
            off_d    = off_full;
            remain_d = REM_W'(len_q) + REM_W'(3);
`ifdef LZRW1_DEC_BOUNDS_CHECK_EN
            if (!off_ok) begin
                err_d = 1'b1;
            end
`endif
        end
        if (emit) begin
            remain_d = remain_q - REM_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            wr_ptr_q    <= '0;
            off_q       <= '0;
            off_hi_q    <= '0;
            len_q       <= '0;
            remain_q    <= '0;
`ifdef LZRW1_DEC_BOUNDS_CHECK_EN
            fill_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wr_ptr_q    <= wr_ptr_d;
            off_q       <= off_d;
            off_hi_q    <= off_hi_d;
            len_q       <= len_d;
            remain_q    <= remain_d;
`ifdef LZRW1_DEC_BOUNDS_CHECK_EN
            fill_q      <= fill_d;
            err_q       <= err_d;
`endif
        end
    end

    // History window; every emitted byte is written before the next read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            hist_q[wr_ptr_q] <= wr_byte;
        end
    end

endmodule
